uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_tick.sv | 30 +++
 rtl/uart_tx_param.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit types and line levels.
// The state set always includes PARITY; it is reachable only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // States in which the line is carrying a frame bit and the bit timer must run.
    function automatic logic in_frame(input uart_tx_state_t s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-period timer: counts OSR uart_clk cycles per bit and pulses bit_end on the last one.
// restart zeroes the count so the first bit of a frame is a full OSR cycles long.
module uart_bit_tick #(
    parameter int OSR = 16
) (
    input  logic uart_clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(OSR - 1);

    logic [CNT_W-1:0] cyc_cnt;

    assign bit_end = en && (cyc_cnt == LAST_CYC);

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (restart) begin
            cyc_cnt <= '0;
        end else if (en) begin
            cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter pulling bytes from a show-ahead-free FIFO (data one cycle after rdreq).
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OSR       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              uart_clk,
    input  logic              rst_n,
    input  logic              tf_empty,
    input  logic [DATA_W-1:0] tf_data,
    output logic              tf_rdreq,
    input  logic              parity_odd,
    output logic              uart_txd,
    output logic              tx_busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_tx_state_t    state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic              txd_q, txd_d;
    logic              bit_end;
    logic              tick_en;
    logic              tick_restart;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    function automatic logic frame_parity(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`else
    logic parity_odd_unused;
    assign parity_odd_unused = parity_odd;
`endif

    // The read strobe is held off for the whole reset so no byte is pulled while the FSM is forced.
    assign tf_rdreq = rst_n && (state == IDLE) && !tf_empty;
    assign tx_busy  = tf_rdreq || (state != IDLE);
    assign uart_txd = txd_q;

    assign tick_en      = in_frame(state);
    assign tick_restart = (state == LOAD);

    uart_bit_tick #(
        .OSR(OSR)
    ) u_bit_tick (
        .uart_clk(uart_clk),
        .rst_n   (rst_n),
        .en      (tick_en),
        .restart (tick_restart),
        .bit_end (bit_end)
    );

    // txd_d always carries the level of the bit that starts on the next cycle,
    // so the registered line changes exactly on bit boundaries.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state)
            IDLE: begin
                txd_d = IDLE_LEVEL;
                if (!tf_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d   = tf_data;
                bit_cnt_d = '0;
                txd_d     = START_LEVEL;
`ifdef UART_TX_PARITY_EN
                par_d     = frame_parity(tf_data, parity_odd);
`endif
                state_d   = START;
            end
            START: begin
                if (bit_end) begin
                    txd_d   = shreg[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        txd_d     = par_q;
                        state_d   = PARITY;
`else
                        txd_d     = IDLE_LEVEL;
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        txd_d     = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    txd_d   = IDLE_LEVEL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                txd_d = IDLE_LEVEL;
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = IDLE_LEVEL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            txd_q   <= IDLE_LEVEL;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            txd_q   <= txd_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations (8/16/1, 8/16/2, 5/4/1) share one FIFO model,
// and every cycle of a frame is checked against a per-cycle expectation queue.
module tb_uart_tx_param;

    logic       uart_clk = 1'b0;
    logic       rst_n;
    logic       tf_empty;
    logic [7:0] tf_data;
    logic       parity_odd;
    int         sel;

    logic e0, e1, e2, rd0, rd1, rd2, txd0, txd1, txd2, busy0, busy1, busy2;
    logic txd_s, rd_s, busy_s;

    always #5 uart_clk = ~uart_clk;

    assign e0 = (sel == 0) ? tf_empty : 1'b1;
    assign e1 = (sel == 1) ? tf_empty : 1'b1;
    assign e2 = (sel == 2) ? tf_empty : 1'b1;

    uart_tx_param #(.DATA_W(8), .OSR(16), .STOP_BITS(1)) dut0 (
        .uart_clk(uart_clk), .rst_n(rst_n), .tf_empty(e0), .tf_data(tf_data),
        .tf_rdreq(rd0), .parity_odd(parity_odd), .uart_txd(txd0), .tx_busy(busy0));

    uart_tx_param #(.DATA_W(8), .OSR(16), .STOP_BITS(2)) dut1 (
        .uart_clk(uart_clk), .rst_n(rst_n), .tf_empty(e1), .tf_data(tf_data),
        .tf_rdreq(rd1), .parity_odd(parity_odd), .uart_txd(txd1), .tx_busy(busy1));

    uart_tx_param #(.DATA_W(5), .OSR(4), .STOP_BITS(1)) dut2 (
        .uart_clk(uart_clk), .rst_n(rst_n), .tf_empty(e2), .tf_data(tf_data[4:0]),
        .tf_rdreq(rd2), .parity_odd(parity_odd), .uart_txd(txd2), .tx_busy(busy2));

    always_comb begin
        txd_s  = txd0;
        rd_s   = rd0;
        busy_s = busy0;
        if (sel == 1) begin
            txd_s = txd1; rd_s = rd1; busy_s = busy1;
        end else if (sel == 2) begin
            txd_s = txd2; rd_s = rd2; busy_s = busy2;
        end
    end

    typedef struct {
        logic [2:0] v;
        int         tid;
        int         idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       rd_seen = 1'b0;
    int         cur_tid = 0;
    int         cur_idx = 0;

    // Single compare point: one expectation consumed per cycle, sampled mid-cycle.
    always @(negedge uart_clk) begin
        exp_t e;
        rd_seen = rd_s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({txd_s, rd_s, busy_s} !== e.v) begin
                n_bad++;
                $display("FAIL test%0d cyc%0d txd/rdreq/busy got %b%b%b want %b",
                         e.tid, e.idx, txd_s, rd_s, busy_s, e.v);
            end
        end
    end

    task automatic push_exp(input logic [2:0] v);
        exp_t e;
        e.v   = v;
        e.tid = cur_tid;
        e.idx = cur_idx;
        cur_idx++;
        exp_q.push_back(e);
    endtask

    task automatic new_test(input int id);
        cur_tid = id;
        cur_idx = 0;
    endtask

    // FIFO model: a strobe seen in the previous cycle delivers the head word now; otherwise the bus is noise.
    task automatic tick();
        @(posedge uart_clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) tf_data = fifo_q.pop_front();
        else tf_data = 8'($urandom);
        tf_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20000 && exp_q.size() > 0; k++) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL test%0d wait expired with %0d expectations pending",
                     cur_tid, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state();
        n_cmp++;
        if ({txd0, rd0, busy0, txd1, rd1, busy1, txd2, rd2, busy2} !== 9'b100_100_100) begin
            n_bad++;
            $display("FAIL test%0d reset state txd/rdreq/busy got %b%b%b %b%b%b %b%b%b want 100 100 100",
                     cur_tid, txd0, rd0, busy0, txd1, rd1, busy1, txd2, rd2, busy2);
        end
    endtask

    task automatic idle_tail(input int n);
        for (int k = 0; k < n; k++) push_exp(3'b100);
    endtask

    // Hand-written bit pattern (index 0 = start bit), preceded by the IDLE strobe cycle and LOAD.
    task automatic push_literal(input logic [15:0] pat, input int nb, input int osr);
        push_exp(3'b111);
        push_exp(3'b101);
        for (int i = 0; i < nb; i++)
            for (int k = 0; k < osr; k++) push_exp({pat[i], 2'b01});
    endtask

    // Frame model: start, data LSB first, optional parity, stop bits; each bit osr cycles.
    task automatic model_frame(input logic [7:0] d, input int dw, input int osr,
                               input int stop, input logic podd, input int lim);
        logic       lv[$];
        logic [2:0] c[$];
        logic       p;
        p = podd;
        lv.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            lv.push_back(d[i]);
            p = p ^ d[i];
        end
`ifdef UART_TX_PARITY_EN
        lv.push_back(p);
`endif
        for (int i = 0; i < stop; i++) lv.push_back(1'b1);
        c.push_back(3'b111);
        c.push_back(3'b101);
        foreach (lv[j])
            for (int k = 0; k < osr; k++) c.push_back({lv[j], 2'b01});
        for (int j = 0; j < c.size() && (lim < 0 || j < lim); j++) push_exp(c[j]);
    endtask

    initial begin
        rst_n      = 1'b1;
        tf_empty   = 1'b1;
        tf_data    = 8'h00;
        parity_odd = 1'b0;
        sel        = 0;
        #1 rst_n   = 1'b0;
        repeat (3) tick();

        // Reset held with data waiting: no strobe, line high, not busy.
        new_test(1);
        fifo_q.push_back(8'hA5);
        tf_empty = 1'b0;
        repeat (3) push_exp(3'b100);
        drain();
        check_reset_state();

        // First frame straight after release: 0xA5.
        new_test(2);
        rst_n = 1'b1;
`ifdef UART_TX_PARITY_EN
        push_literal(16'b0000_0101_0100_1010, 11, 16);
`else
        push_literal(16'b0000_0011_0100_1010, 10, 16);
`endif
        idle_tail(4);
        drain();

        // 0xA5 with odd parity; parity_odd and tf_data disturbed mid-frame.
        new_test(3);
        parity_odd = 1'b1;
        fifo_q.push_back(8'hA5);
        tf_empty = 1'b0;
`ifdef UART_TX_PARITY_EN
        push_literal(16'b0000_0111_0100_1010, 11, 16);
`else
        push_literal(16'b0000_0011_0100_1010, 10, 16);
`endif
        idle_tail(4);
        repeat (6) tick();
        parity_odd = 1'b0;
        drain();

        // Empty FIFO for 1000 cycles.
        new_test(4);
        idle_tail(1000);
        drain();

        // Two stop bits, 0x00 then 0xFF back to back.
        new_test(5);
        sel = 1;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        tf_empty = 1'b0;
        model_frame(8'h00, 8, 16, 2, parity_odd, -1);
        model_frame(8'hFF, 8, 16, 2, parity_odd, -1);
        idle_tail(4);
        drain();

        // Reset 50 cycles into a frame, then a clean frame after release.
        new_test(6);
        sel = 0;
        fifo_q.push_back(8'hC3);
        tf_empty = 1'b0;
        model_frame(8'hC3, 8, 16, 1, parity_odd, 52);
        drain();
        rst_n = 1'b0;
        fifo_q.push_back(8'h96);
        tf_empty = 1'b0;
        repeat (3) push_exp(3'b100);
        drain();
        check_reset_state();
        new_test(7);
        rst_n = 1'b1;
        model_frame(8'h96, 8, 16, 1, parity_odd, -1);
        idle_tail(4);
        drain();

        // DATA_W=5, OSR=4: 0x1F.
        new_test(8);
        sel = 2;
        fifo_q.push_back(8'h1F);
        tf_empty = 1'b0;
`ifdef UART_TX_PARITY_EN
        push_literal(16'b0000_0000_1111_1110, 8, 4);
`else
        push_literal(16'b0000_0000_0111_1110, 7, 4);
`endif
        idle_tail(3);
        drain();

        // Narrow frames back to back with odd parity selected.
        new_test(9);
        parity_odd = 1'b1;
        fifo_q.push_back(8'h0A);
        fifo_q.push_back(8'h15);
        fifo_q.push_back(8'h00);
        tf_empty = 1'b0;
        model_frame(8'h0A, 5, 4, 1, 1'b1, -1);
        model_frame(8'h15, 5, 4, 1, 1'b1, -1);
        model_frame(8'h00, 5, 4, 1, 1'b1, -1);
        idle_tail(3);
        drain();

        // Default configuration, mixed bytes back to back.
        new_test(10);
        sel = 0;
        fifo_q.push_back(8'h5A);
        fifo_q.push_back(8'hFF);
        fifo_q.push_back(8'h01);
        tf_empty = 1'b0;
        model_frame(8'h5A, 8, 16, 1, 1'b1, -1);
        model_frame(8'hFF, 8, 16, 1, 1'b1, -1);
        model_frame(8'h01, 8, 16, 1, 1'b1, -1);
        idle_tail(4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
